// File: rtl/stepper_drive_axes_if.sv
// Request/status bundle between the tracker controller and the stepper drive.
// Ports: per-axis 2-bit move requests in, coil drives, positions and theta_limit back.
interface stepper_drive_axes_if;
    logic [1:0]  s_out_theta_pos;
    logic [1:0]  s_out_theta_neg;
    logic [1:0]  s_out_phi_pos;
    logic [1:0]  s_out_phi_neg;
    logic [3:0]  coil_theta;
    logic [3:0]  coil_phi;
    logic [15:0] theta_actual;
    logic [15:0] phi_actual;
    logic        theta_limit;

    modport master (
        output s_out_theta_pos, s_out_theta_neg,
        output s_out_phi_pos, s_out_phi_neg,
        input  coil_theta, coil_phi,
        input  theta_actual, phi_actual, theta_limit
    );

    modport slave (
        input  s_out_theta_pos, s_out_theta_neg,
        input  s_out_phi_pos, s_out_phi_neg,
        output coil_theta, coil_phi,
        output theta_actual, phi_actual, theta_limit
    );
endinterface

// File: rtl/stepper_drive_axes.sv
// Two-axis half-step unipolar stepper drive with absolute position tracking.
// Ports: clk, rst (sync, active high), drv (slave side of stepper_drive_axes_if).
module stepper_drive_axes #(
    parameter int STEP_DIV       = 50000,
    parameter int STEPS_PER_UNIT = 11,
    parameter int DIR_PAUSE      = 2,
    parameter int THETA_MIN      = 0,
    parameter int THETA_MAX      = 90,
    parameter int THETA_INIT     = 0,
    parameter int PHI_INIT       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    stepper_drive_axes_if.slave  drv
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SUB_W = $clog2(STEPS_PER_UNIT + 1);
    localparam int PAU_W = (DIR_PAUSE > 1) ? $clog2(DIR_PAUSE + 1) : 1;

    localparam logic [15:0] T_MIN  = 16'(THETA_MIN);
    localparam logic [15:0] T_MAX  = 16'(THETA_MAX);
    localparam logic [15:0] T_INIT = 16'(THETA_INIT);
    localparam logic [15:0] P_INIT = 16'(PHI_INIT);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEPS_PER_UNIT - 1);
    localparam logic [PAU_W-1:0] PAU_LAST = PAU_W'(DIR_PAUSE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN_POS,
        RUN_NEG,
        PAUSE
    } state_t;

    function automatic logic [3:0] seq(input logic [2:0] p);
        logic [3:0] c;
        c = 4'b0000;
        case (p)
            3'd0: c = 4'b0001;
            3'd1: c = 4'b0011;
            3'd2: c = 4'b0010;
            3'd3: c = 4'b0110;
            3'd4: c = 4'b0100;
            3'd5: c = 4'b1100;
            3'd6: c = 4'b1000;
            3'd7: c = 4'b1001;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // Phi is a full circle, theta moves are pre-checked against its limits.
    function automatic logic [15:0] move(
        input logic        wrap,
        input logic [15:0] p,
        input logic        up
    );
        logic [15:0] r;
        if (up)
            r = (wrap && p == 16'd359) ? 16'd0 : p + 16'd1;
        else
            r = (wrap && p == 16'd0) ? 16'd359 : p - 16'd1;
        return r;
    endfunction

    logic [DIV_W-1:0] div_q;
    logic             tick;

    state_t           state_q [2];
    state_t           state_d [2];
    logic [2:0]       phase_q [2];
    logic [2:0]       phase_d [2];
    logic [SUB_W-1:0] sub_q   [2];
    logic [SUB_W-1:0] sub_d   [2];
    logic [PAU_W-1:0] pcnt_q  [2];
    logic [PAU_W-1:0] pcnt_d  [2];
    logic [15:0]      pos_q   [2];
    logic [15:0]      pos_d   [2];
    logic [3:0]       coil_q  [2];
    logic [3:0]       coil_d  [2];
    logic             limit_q;
    logic             limit_d;

    logic [1:0] raw_pos;
    logic [1:0] raw_neg;
    logic [1:0] go_pos;
    logic [1:0] go_neg;
    logic [1:0] blocked;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            div_q <= '0;
        else if (tick)
            div_q <= '0;
        else
            div_q <= div_q + 1'b1;
    end

    // Only the exact 2'b01 encoding is a request; both at once cancel.
    assign raw_pos[0] = (drv.s_out_theta_pos == 2'b01);
    assign raw_neg[0] = (drv.s_out_theta_neg == 2'b01);
    assign raw_pos[1] = (drv.s_out_phi_pos == 2'b01);
    assign raw_neg[1] = (drv.s_out_phi_neg == 2'b01);
    assign go_pos     = raw_pos & ~raw_neg;
    assign go_neg     = raw_neg & ~raw_pos;

    // Theta stalls with coils energised at either end stop; phi never does.
    assign blocked[0] = (state_q[0] == RUN_POS && pos_q[0] == T_MAX)
                     || (state_q[0] == RUN_NEG && pos_q[0] == T_MIN);
    assign blocked[1] = 1'b0;

    always_comb begin
        limit_d = blocked[0];
        for (int a = 0; a < 2; a++) begin
            state_d[a] = state_q[a];
            phase_d[a] = phase_q[a];
            sub_d[a]   = sub_q[a];
            pcnt_d[a]  = pcnt_q[a];
            pos_d[a]   = pos_q[a];
            coil_d[a]  = 4'b0000;

            unique case (state_q[a])
                IDLE: begin
                    if (go_pos[a])
                        state_d[a] = RUN_POS;
                    else if (go_neg[a])
                        state_d[a] = RUN_NEG;
                end
                RUN_POS, RUN_NEG: begin
                    if ((state_q[a] == RUN_POS) ? go_pos[a] : go_neg[a]) begin
                        if (tick && !blocked[a]) begin
                            if (state_q[a] == RUN_POS)
                                phase_d[a] = phase_q[a] + 3'd1;
                            else
                                phase_d[a] = phase_q[a] - 3'd1;
                            if (sub_q[a] == SUB_LAST) begin
                                sub_d[a] = '0;
                                pos_d[a] = move(a == 1, pos_q[a],
                                                state_q[a] == RUN_POS);
                            end else begin
                                sub_d[a] = sub_q[a] + 1'b1;
                            end
                        end
                    end else if ((state_q[a] == RUN_POS) ? go_neg[a] : go_pos[a]) begin
                        state_d[a] = PAUSE;
                        sub_d[a]   = '0;
                        pcnt_d[a]  = '0;
                    end else begin
                        state_d[a] = IDLE;
                    end
                end
                PAUSE: begin
                    if (tick) begin
                        if (pcnt_q[a] == PAU_LAST) begin
                            state_d[a] = IDLE;
                            pcnt_d[a]  = '0;
                        end else begin
                            pcnt_d[a] = pcnt_q[a] + 1'b1;
                        end
                    end
                end
                default: state_d[a] = IDLE;
            endcase

            // Coils follow the next phase so both change on the same edge.
            if (state_d[a] == RUN_POS || state_d[a] == RUN_NEG)
                coil_d[a] = seq(phase_d[a]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 2; a++) begin
                state_q[a] <= IDLE;
                phase_q[a] <= '0;
                sub_q[a]   <= '0;
                pcnt_q[a]  <= '0;
                coil_q[a]  <= 4'b0000;
            end
            pos_q[0] <= T_INIT;
            pos_q[1] <= P_INIT;
            limit_q  <= 1'b0;
        end else begin
            for (int a = 0; a < 2; a++) begin
                state_q[a] <= state_d[a];
                phase_q[a] <= phase_d[a];
                sub_q[a]   <= sub_d[a];
                pcnt_q[a]  <= pcnt_d[a];
                pos_q[a]   <= pos_d[a];
                coil_q[a]  <= coil_d[a];
            end
            limit_q <= limit_d;
        end
    end

    assign drv.coil_theta   = coil_q[0];
    assign drv.coil_phi     = coil_q[1];
    assign drv.theta_actual = pos_q[0];
    assign drv.phi_actual   = pos_q[1];
    assign drv.theta_limit  = limit_q;

endmodule

// File: tb/tb_stepper_drive_axes.sv
// Randomised bench for stepper_drive_axes against a behavioural model.
// Ports: none; drives the interface and checks every cycle.
module tb_stepper_drive_axes;

    localparam int STEP_DIV  = 4;
    localparam int SPU       = 2;
    localparam int DIR_PAUSE = 2;
    localparam int TMIN      = 0;
    localparam int TMAX      = 90;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stepper_drive_axes_if drv();

    stepper_drive_axes #(
        .STEP_DIV       (STEP_DIV),
        .STEPS_PER_UNIT (SPU),
        .DIR_PAUSE      (DIR_PAUSE),
        .THETA_MIN      (TMIN),
        .THETA_MAX      (TMAX),
        .THETA_INIT     (0),
        .PHI_INIT       (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .drv (drv)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    logic [3:0] seq_tab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0100, 4'b1100, 4'b1000, 4'b1001};

    // Model: dir 0 = stopped, +1/-1 = moving; pause counts remaining ticks.
    int m_cnt;
    int m_dir   [2];
    int m_pause [2];
    int m_phase [2];
    int m_sub   [2];
    int m_pos   [2];
    bit m_lim;

    function automatic int decode(input logic [1:0] p, input logic [1:0] n);
        bit up, dn;
        up = (p == 2'b01);
        dn = (n == 2'b01);
        if (up && !dn) return 1;
        if (dn && !up) return -1;
        return 0;
    endfunction

    task automatic model_edge(input bit r, input logic [1:0] tp, input logic [1:0] tn,
                              input logic [1:0] pp, input logic [1:0] pn);
        int req [2];
        bit tk;
        bit stop;
        if (r) begin
            m_cnt = 0;
            m_lim = 0;
            for (int a = 0; a < 2; a++) begin
                m_dir[a] = 0; m_pause[a] = 0; m_phase[a] = 0;
                m_sub[a] = 0; m_pos[a] = 0;
            end
            return;
        end
        req[0] = decode(tp, tn);
        req[1] = decode(pp, pn);
        tk = (m_cnt == STEP_DIV - 1);
        m_cnt = (m_cnt + 1) % STEP_DIV;
        m_lim = (m_dir[0] == 1 && m_pos[0] == TMAX) ||
                (m_dir[0] == -1 && m_pos[0] == TMIN);
        for (int a = 0; a < 2; a++) begin
            stop = (a == 0) && m_lim;
            if (m_pause[a] > 0) begin
                if (tk) m_pause[a]--;
            end else if (m_dir[a] == 0) begin
                m_dir[a] = req[a];
            end else if (req[a] == m_dir[a]) begin
                if (tk && !stop) begin
                    m_phase[a] = (m_phase[a] + m_dir[a] + 8) % 8;
                    m_sub[a]++;
                    if (m_sub[a] == SPU) begin
                        m_sub[a] = 0;
                        if (a == 0) m_pos[a] = m_pos[a] + m_dir[a];
                        else m_pos[a] = (m_pos[a] + m_dir[a] + 360) % 360;
                    end
                end
            end else if (req[a] == -m_dir[a]) begin
                m_dir[a] = 0;
                m_pause[a] = DIR_PAUSE;
                m_sub[a] = 0;
            end else begin
                m_dir[a] = 0;
            end
        end
    endtask

    task automatic apply(input logic [1:0] tp, input logic [1:0] tn,
                         input logic [1:0] pp, input logic [1:0] pn,
                         input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            drv.s_out_theta_pos = tp;
            drv.s_out_theta_neg = tn;
            drv.s_out_phi_pos   = pp;
            drv.s_out_phi_neg   = pn;
            rst = r;
            @(posedge clk);
            model_edge(r, tp, tn, pp, pn);
            #1;
            check("coil_theta", drv.coil_theta,
                  m_dir[0] != 0 ? seq_tab[m_phase[0]] : 4'b0000);
            check("coil_phi", drv.coil_phi,
                  m_dir[1] != 0 ? seq_tab[m_phase[1]] : 4'b0000);
            check("theta_actual", drv.theta_actual, m_pos[0]);
            check("phi_actual", drv.phi_actual, m_pos[1]);
            check("theta_limit", drv.theta_limit, m_lim);
        end
    endtask

    function automatic logic [1:0] rnd_enc();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return 2'b00;
        if (k < 8) return 2'b01;
        if (k == 8) return 2'b11;
        return 2'b10;
    endfunction

    initial begin
        drv.s_out_theta_pos = 2'b00;
        drv.s_out_theta_neg = 2'b00;
        drv.s_out_phi_pos   = 2'b00;
        drv.s_out_phi_neg   = 2'b00;

        apply(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3);
        check("rst_coil", drv.coil_theta, 4'b0000);
        check("rst_theta", drv.theta_actual, 0);
        check("rst_limit", drv.theta_limit, 0);

        apply(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 10);
        apply(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1);
        check("midrun_rst_coil", drv.coil_theta, 4'b0000);
        apply(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1);
        check("restart_phase0", drv.coil_theta, 4'b0001);
        apply(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 40);
        apply(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2);
        check("release_idle", drv.coil_theta, 4'b0000);

        apply(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1);
        apply(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 12);
        check("phi_wrap", drv.phi_actual, 359);

        apply(2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 6);
        apply(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 6);
        check("bad_enc_idle", drv.coil_theta, 4'b0000);

        apply(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1);
        apply(2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 800);
        check("at_max", drv.theta_actual, TMAX);
        check("limit_set", drv.theta_limit, 1);
        apply(2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 14);
        check("limit_clear", drv.theta_limit, 0);
        apply(2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 30);

        for (int s = 0; s < 200; s++) begin
            apply(rnd_enc(), rnd_enc(), rnd_enc(), rnd_enc(),
                  $urandom_range(0, 99) == 0, $urandom_range(1, 30));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
